// File: rtl/regfile_bist.sv
// BIST initiator for a 32x32 register file: clear, zero-check, pattern write, pattern read-back.
// Outputs are registered from the current state, so each phase appears one cycle after the state enters it.
module regfile_bist #(
    parameter int unsigned MULT = 5,
    parameter logic [31:0] SEED = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        rf_rst,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic [4:0]  rf_raddr1,
    output logic [4:0]  rf_raddr2,
    input  logic [31:0] rf_rdata1,
    input  logic [31:0] rf_rdata2,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [7:0]  err_cnt,
    output logic [4:0]  fail_addr,
    output logic        fail_port,
    output logic        fail_phase
);

    localparam int unsigned AW = 5;
    localparam int unsigned DW = 32;
    localparam int unsigned CW = 8;

    typedef enum logic [2:0] {IDLE, CLR, CHK0, WR, RD, DONE} state_t;

    state_t          state, state_nxt;
    logic [AW-1:0]   cnt, cnt_nxt;
    logic            chk_q, chk_nxt;
    logic            rd_q, rd_nxt;
    logic            accept, mis1, mis2;
    logic            rf_rst_nxt, rf_we_nxt, busy_nxt, done_nxt, pass_nxt;
    logic [AW-1:0]   rf_waddr_nxt, rf_raddr1_nxt, rf_raddr2_nxt, fail_addr_nxt;
    logic [DW-1:0]   rf_wdata_nxt;
    logic [CW-1:0]   err_nxt;
    logic            fail_port_nxt, fail_phase_nxt;

    function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
        return (DW'(a) * DW'(MULT)) ^ SEED;
    endfunction

    // State, counter and every output register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            chk_q      <= 1'b0;
            rd_q       <= 1'b0;
            rf_rst     <= 1'b0;
            rf_we      <= 1'b0;
            rf_waddr   <= '0;
            rf_wdata   <= '0;
            rf_raddr1  <= '0;
            rf_raddr2  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_cnt    <= '0;
            fail_addr  <= '0;
            fail_port  <= 1'b0;
            fail_phase <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            chk_q      <= chk_nxt;
            rd_q       <= rd_nxt;
            rf_rst     <= rf_rst_nxt;
            rf_we      <= rf_we_nxt;
            rf_waddr   <= rf_waddr_nxt;
            rf_wdata   <= rf_wdata_nxt;
            rf_raddr1  <= rf_raddr1_nxt;
            rf_raddr2  <= rf_raddr2_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
            pass       <= pass_nxt;
            err_cnt    <= err_nxt;
            fail_addr  <= fail_addr_nxt;
            fail_port  <= fail_port_nxt;
            fail_phase <= fail_phase_nxt;
        end
    end

    // Next state, next outputs and the compare of the read data presented this cycle
    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        chk_nxt        = 1'b0;
        rd_nxt         = 1'b0;
        rf_rst_nxt     = 1'b0;
        rf_we_nxt      = 1'b0;
        rf_waddr_nxt   = '0;
        rf_wdata_nxt   = '0;
        rf_raddr1_nxt  = '0;
        rf_raddr2_nxt  = '0;
        busy_nxt       = 1'b0;
        done_nxt       = 1'b0;
        mis1           = 1'b0;
        mis2           = 1'b0;
        fail_addr_nxt  = fail_addr;
        fail_port_nxt  = fail_port;
        fail_phase_nxt = fail_phase;

        // busy gates the one DONE cycle whose outputs still show the last read
        accept = start && !busy && (state == IDLE || state == DONE);

        if (chk_q) begin
            mis1 = (rf_rdata1 != '0);
            mis2 = (rf_rdata2 != '0);
        end else if (rd_q) begin
            mis1 = (rf_rdata1 != pat(rf_raddr1));
            mis2 = (rf_rdata2 != pat(rf_raddr2));
        end
        err_nxt = err_cnt + CW'(mis1) + CW'(mis2);
        if (err_cnt == '0 && (mis1 || mis2)) begin
            fail_addr_nxt  = mis1 ? rf_raddr1 : rf_raddr2;
            fail_port_nxt  = !mis1;
            fail_phase_nxt = rd_q;
        end

        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = CLR;
                    cnt_nxt   = '0;
                end
            end
            CLR: begin
                rf_rst_nxt = 1'b1;
                busy_nxt   = 1'b1;
                cnt_nxt    = '0;
                state_nxt  = CHK0;
            end
            CHK0: begin
                chk_nxt       = 1'b1;
                busy_nxt      = 1'b1;
                rf_raddr1_nxt = cnt;
                rf_raddr2_nxt = ~cnt;
                cnt_nxt       = cnt + AW'(1);
                if (cnt == '1) state_nxt = WR;
            end
            WR: begin
                busy_nxt     = 1'b1;
                rf_we_nxt    = 1'b1;
                rf_waddr_nxt = cnt;
                rf_wdata_nxt = pat(cnt);
                cnt_nxt      = cnt + AW'(1);
                if (cnt == '1) state_nxt = RD;
            end
            RD: begin
                rd_nxt        = 1'b1;
                busy_nxt      = 1'b1;
                rf_raddr1_nxt = cnt;
                rf_raddr2_nxt = ~cnt;
                cnt_nxt       = cnt + AW'(1);
                if (cnt == '1) state_nxt = DONE;
            end
            DONE: begin
                if (accept) begin
                    state_nxt = CLR;
                    cnt_nxt   = '0;
                end else begin
                    done_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (accept) begin
            err_nxt        = '0;
            fail_addr_nxt  = '0;
            fail_port_nxt  = 1'b0;
            fail_phase_nxt = 1'b0;
        end
        pass_nxt = done_nxt && (err_nxt == '0);
    end

endmodule

// File: tb/tb_regfile_bist.sv
// Self-checking bench for regfile_bist: two DUTs (SEED 0 and all-ones) each driving a behavioural
// register-file model with selectable faults; results are checked against a loop-level reference run.
module tb_regfile_bist;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic start0, start1;

    logic        rf_rst0, rf_we0, busy0, done0, pass0, fail_port0, fail_phase0;
    logic [4:0]  rf_waddr0, rf_raddr1_0, rf_raddr2_0, fail_addr0;
    logic [31:0] rf_wdata0, rf_rdata1_0, rf_rdata2_0;
    logic [7:0]  err_cnt0;

    logic        rf_rst1, rf_we1, busy1, done1, pass1, fail_port1, fail_phase1;
    logic [4:0]  rf_waddr1, rf_raddr1_1, rf_raddr2_1, fail_addr1;
    logic [31:0] rf_wdata1, rf_rdata1_1, rf_rdata2_1;
    logic [7:0]  err_cnt1;

    regfile_bist #(.MULT(5), .SEED(32'h0000_0000)) u_dut0 (
        .clk(clk), .rst(rst), .start(start0),
        .rf_rst(rf_rst0), .rf_we(rf_we0), .rf_waddr(rf_waddr0), .rf_wdata(rf_wdata0),
        .rf_raddr1(rf_raddr1_0), .rf_raddr2(rf_raddr2_0),
        .rf_rdata1(rf_rdata1_0), .rf_rdata2(rf_rdata2_0),
        .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err_cnt0),
        .fail_addr(fail_addr0), .fail_port(fail_port0), .fail_phase(fail_phase0)
    );

    regfile_bist #(.MULT(5), .SEED(32'hFFFF_FFFF)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1),
        .rf_rst(rf_rst1), .rf_we(rf_we1), .rf_waddr(rf_waddr1), .rf_wdata(rf_wdata1),
        .rf_raddr1(rf_raddr1_1), .rf_raddr2(rf_raddr2_1),
        .rf_rdata1(rf_rdata1_1), .rf_rdata2(rf_rdata2_1),
        .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err_cnt1),
        .fail_addr(fail_addr1), .fail_port(fail_port1), .fail_phase(fail_phase1)
    );

    // Register-file models: falling-edge write/clear, asynchronous read.
    // fault on DUT0: 0 ideal, 1 stuck-at-1 bit, 2 ignores rf_rst, 3 dead write enable
    int          fault;
    logic [4:0]  stuck_addr, stuck_bit;
    logic        wipe;
    logic [31:0] mem0 [32];
    logic [31:0] mem1 [32];

    always @(negedge clk) begin
        if (wipe || (rf_rst0 && fault != 2)) begin
            for (int i = 0; i < 32; i++) mem0[i] <= '0;
        end else if (rf_we0 && fault != 3) begin
            mem0[rf_waddr0] <= rf_wdata0;
        end
    end

    always @(negedge clk) begin
        if (wipe || rf_rst1) begin
            for (int i = 0; i < 32; i++) mem1[i] <= '0;
        end else if (rf_we1) begin
            mem1[rf_waddr1] <= rf_wdata1;
        end
    end

    always_comb begin
        rf_rdata1_0 = mem0[rf_raddr1_0] |
                      ((fault == 1 && rf_raddr1_0 == stuck_addr) ? (32'h1 << stuck_bit) : 32'h0);
        rf_rdata2_0 = mem0[rf_raddr2_0] |
                      ((fault == 1 && rf_raddr2_0 == stuck_addr) ? (32'h1 << stuck_bit) : 32'h0);
        rf_rdata1_1 = mem1[rf_raddr1_1];
        rf_rdata2_1 = mem1[rf_raddr2_1];
    end

    int n_cmp = 0;
    int n_fail = 0;

    // Snapshot of the selected DUT's outputs
    logic        c_busy, c_done, c_pass, c_rfrst, c_we, c_fport, c_fphase;
    logic [4:0]  c_faddr, c_waddr;
    logic [31:0] c_wdata;
    logic [7:0]  c_err;
    logic [66:0] c_outs;

    task automatic sample(input int inst);
        if (inst == 0) begin
            {c_busy, c_done, c_pass, c_rfrst, c_we} = {busy0, done0, pass0, rf_rst0, rf_we0};
            {c_faddr, c_fport, c_fphase, c_err} = {fail_addr0, fail_port0, fail_phase0, err_cnt0};
            {c_waddr, c_wdata} = {rf_waddr0, rf_wdata0};
            c_outs = {busy0, done0, pass0, err_cnt0, fail_addr0, fail_port0, fail_phase0,
                      rf_rst0, rf_we0, rf_waddr0, rf_wdata0, rf_raddr1_0, rf_raddr2_0};
        end else begin
            {c_busy, c_done, c_pass, c_rfrst, c_we} = {busy1, done1, pass1, rf_rst1, rf_we1};
            {c_faddr, c_fport, c_fphase, c_err} = {fail_addr1, fail_port1, fail_phase1, err_cnt1};
            {c_waddr, c_wdata} = {rf_waddr1, rf_wdata1};
            c_outs = {busy1, done1, pass1, err_cnt1, fail_addr1, fail_port1, fail_phase1,
                      rf_rst1, rf_we1, rf_waddr1, rf_wdata1, rf_raddr1_1, rf_raddr2_1};
        end
    endtask

    task automatic set_start(input int inst, input logic v);
        if (inst == 0) start0 = v;
        else start1 = v;
    endtask

    // Reference: the whole run as four array sweeps over a copy of the model's storage
    logic [31:0] rmem [32];
    int          e_err;
    logic [4:0]  e_addr;
    logic        e_port, e_phase;

    function automatic logic [31:0] mpat(input int inst, input int a);
        return 32'(a * 5) ^ ((inst == 1) ? 32'hFFFF_FFFF : 32'h0);
    endfunction

    function automatic logic [31:0] mread(input int inst, input int a);
        return rmem[a] | ((inst == 0 && fault == 1 && a == int'(stuck_addr)) ?
                          (32'h1 << stuck_bit) : 32'h0);
    endfunction

    task automatic note(input int a, input logic port, input logic phase);
        if (e_err == 0) begin
            e_addr  = 5'(a);
            e_port  = port;
            e_phase = phase;
        end
        e_err++;
    endtask

    task automatic ref_run(input int inst);
        for (int i = 0; i < 32; i++) rmem[i] = (inst == 0) ? mem0[i] : mem1[i];
        e_err = 0; e_addr = '0; e_port = 1'b0; e_phase = 1'b0;
        if (!(inst == 0 && fault == 2))
            for (int i = 0; i < 32; i++) rmem[i] = '0;
        for (int a = 0; a < 32; a++) begin
            if (mread(inst, a) != 32'h0) note(a, 1'b0, 1'b0);
            if (mread(inst, 31 - a) != 32'h0) note(31 - a, 1'b1, 1'b0);
        end
        if (!(inst == 0 && fault == 3))
            for (int a = 0; a < 32; a++) rmem[a] = mpat(inst, a);
        for (int a = 0; a < 32; a++) begin
            if (mread(inst, a) != mpat(inst, a)) note(a, 1'b0, 1'b1);
            if (mread(inst, 31 - a) != mpat(inst, 31 - a)) note(31 - a, 1'b1, 1'b1);
        end
    endtask

    task automatic do_wipe();
        wipe = 1'b1;
        @(posedge clk); #1;
        wipe = 1'b0;
    endtask

    // One complete run from a start pulse; poke_k >= 1 re-pulses start after edge N+poke_k
    task automatic run(input int inst, input int poke_k, input string tag);
        int busy_n, done_k, wr_n;
        logic [31:0] wmask, w_exp;
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        ref_run(inst);
        set_start(inst, 1'b1);
        @(posedge clk); #1;
        set_start(inst, 1'b0);
        busy_n = 0; done_k = 0; wr_n = 0; wmask = '0;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk); #1;
            sample(inst);
            if (k == 1) begin
                n_cmp++;
                if ({c_busy, c_rfrst} !== 2'b11) begin
                    n_fail++;
                    $display("FAIL %s clr_cycle: busy,rf_rst got %b required 11", tag, {c_busy, c_rfrst});
                end
            end
            if (c_busy === 1'b1) busy_n++;
            if (c_done === 1'b1 && done_k == 0) done_k = k;
            if (c_we === 1'b1) begin
                wr_n++;
                wmask[c_waddr] = 1'b1;
                w_exp = mpat(inst, int'(c_waddr));
                n_cmp++;
                if (c_wdata !== w_exp) begin
                    n_fail++;
                    $display("FAIL %s wdata[%0d]: got %h required %h", tag, c_waddr, c_wdata, w_exp);
                end
            end
            set_start(inst, (k == poke_k) ? 1'b1 : 1'b0);
        end
        n_cmp++;
        if (busy_n != 97) begin
            n_fail++; $display("FAIL %s busy_cycles: got %0d required 97", tag, busy_n);
        end
        n_cmp++;
        if (done_k != 98) begin
            n_fail++; $display("FAIL %s done_edge: got N+%0d required N+98", tag, done_k);
        end
        n_cmp++;
        if (wr_n != 32 || wmask !== 32'hFFFF_FFFF) begin
            n_fail++; $display("FAIL %s writes: got %0d mask %h required 32 mask ffffffff", tag, wr_n, wmask);
        end
        n_cmp++;
        if (c_err !== 8'(e_err)) begin
            n_fail++; $display("FAIL %s err_cnt: got %0d required %0d", tag, c_err, e_err);
        end
        n_cmp++;
        if ({c_done, c_pass} !== {1'b1, e_err == 0}) begin
            n_fail++; $display("FAIL %s done,pass: got %b required %b", tag, {c_done, c_pass}, {1'b1, e_err == 0});
        end
        n_cmp++;
        if ({c_faddr, c_fport, c_fphase} !== {e_addr, e_port, e_phase}) begin
            n_fail++;
            $display("FAIL %s fail_fields: got addr %0d port %0d phase %0d required addr %0d port %0d phase %0d",
                     tag, c_faddr, c_fport, c_fphase, e_addr, e_port, e_phase);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; start0 = 1'b0; start1 = 1'b0; fault = 0;
        stuck_addr = '0; stuck_bit = '0;
        wipe = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        wipe = 1'b0;
        for (int i = 0; i < 2; i++) begin
            sample(i);
            n_cmp++;
            if (c_outs !== '0) begin
                n_fail++; $display("FAIL reset_outputs[%0d]: got %h required 0", i, c_outs);
            end
        end
        rst = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        sample(0);
        n_cmp++;
        if ({c_busy, c_done, c_rfrst} !== 3'b000) begin
            n_fail++; $display("FAIL idle_hold: busy,done,rf_rst got %b required 000", {c_busy, c_done, c_rfrst});
        end
    endtask

    task automatic test_ideal();
        fault = 0;
        run(0, -1, "ideal");
        run(0, -1, "back_to_back");
    endtask

    task automatic test_stuck();
        fault = 1; stuck_addr = 5'd6; stuck_bit = 5'd0;
        run(0, -1, "stuck_6_0");
        for (int r = 0; r < 3; r++) begin
            stuck_addr = 5'($urandom_range(0, 31));
            stuck_bit  = 5'($urandom_range(0, 31));
            run(0, -1, "stuck_rand");
        end
        fault = 0;
    endtask

    task automatic test_ignore_rst();
        fault = 2;
        do_wipe();
        run(0, -1, "norst_first");
        run(0, -1, "norst_second");
        fault = 0;
    endtask

    task automatic test_dead_we();
        fault = 3;
        run(0, -1, "dead_we");
        fault = 0;
    endtask

    task automatic test_seed();
        run(1, -1, "seed_ones");
    endtask

    task automatic test_start_mid_wr();
        fault = 0;
        run(0, $urandom_range(34, 64), "start_mid_wr");
    endtask

    task automatic test_rst_mid_rd();
        int hit;
        fault = 0;
        hit = $urandom_range(66, 96);
        start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        repeat (hit) begin @(posedge clk); #1; end
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        sample(0);
        n_cmp++;
        if (c_outs !== '0) begin
            n_fail++; $display("FAIL rst_mid_rd: got %h required 0", c_outs);
        end
        repeat (2) begin @(posedge clk); #1; end
        sample(0);
        n_cmp++;
        if ({c_busy, c_done, c_rfrst} !== 3'b000) begin
            n_fail++; $display("FAIL rst_idle: busy,done,rf_rst got %b required 000", {c_busy, c_done, c_rfrst});
        end
        run(0, -1, "after_rst");
    endtask

    initial begin
        test_reset();
        test_ideal();
        test_stuck();
        test_ignore_rst();
        test_dead_we();
        test_seed();
        test_start_mid_wr();
        test_rst_mid_rd();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
